sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have these parameters:
- data_width_p, 8: word width.
- mem_depth_p, 16: storage depth in words; SHALL equal 2**addr_size_p.
- addr_size_p, 4: pointer width.
- afull_thresh_p, 14: almost_full threshold, 1..mem_depth_p.
- aempty_thresh_p, 2: almost_empty threshold, 0..mem_depth_p-1.
- fwft_p, 0: 0 = registered read, 1 = first-word-fall-through.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  data_width_p  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read/pop request.
- flush  in  1  synchronous content discard.
- clr_err  in  1  clears sticky error flags.
- data_out  out  data_width_p  read data.
- full  out  1  count == mem_depth_p.
- empty  out  1  count == 0.
- almost_full  out  1  count >= afull_thresh_p.
- almost_empty  out  1  count <= aempty_thresh_p.
- count  out  addr_size_p+1  words stored, 0..mem_depth_p.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-003 Write accept: wr_en && !full; the word SHALL be stored at wr_ptr, and wr_ptr SHALL increment modulo mem_depth_p.
REQ-004 Read accept: rd_en && !empty; rd_ptr SHALL increment modulo mem_depth_p.
REQ-005 Pointer wrap SHALL be natural addr_size_p-bit rollover; full and empty SHALL be decoded from count only, never from pointer equality.
REQ-006 count SHALL be +1 on write-only accept, -1 on read-only accept, and unchanged on simultaneous accepts or on no accept.
REQ-007 Simultaneous wr_en and rd_en while full: only the read SHALL be accepted; the write SHALL be dropped, count SHALL become mem_depth_p-1, and overflow SHALL be set.
REQ-008 Simultaneous wr_en and rd_en while empty: only the write SHALL be accepted, count SHALL become 1, and underflow SHALL be set.
REQ-009 full, empty, almost_full, almost_empty and count SHALL all be registered and SHALL reflect the accepts of the previous edge.
REQ-010 fwft_p=0: on a read accept, data_out SHALL load mem[rd_ptr] at that edge (1-cycle latency) and SHALL otherwise hold its value.
REQ-011 fwft_p=1: data_out SHALL present mem[rd_ptr] combinationally whenever !empty; a read accept pops that word. A word written into an empty FIFO SHALL appear on data_out the cycle after the write accept, when empty deasserts. data_out is don't-care while empty.
REQ-012 overflow SHALL set on any edge with wr_en && full; underflow SHALL set on any edge with rd_en && empty. Both SHALL hold until clr_err or rst; if a set condition and clr_err coincide, the set SHALL win.
REQ-013 flush SHALL zero wr_ptr, rd_ptr and count at the edge, overriding wr_en and rd_en in the same cycle. flush SHALL NOT alter memory contents, data_out or the error flags.
REQ-014 Memory SHALL be a simple dual-port array, write-first-free: a same-cycle read of the slot being written SHALL NOT occur, because empty/full gating prevents it.

Reset
REQ-015 When rst=1 at an edge, the block SHALL set:
- wr_ptr=0, rd_ptr=0, count=0.
- empty=1, full=0, almost_empty=1, almost_full=0.
- overflow=0, underflow=0, data_out=0.
REQ-016 rst SHALL override flush, wr_en, rd_en and clr_err; memory contents SHALL NOT be reset.
REQ-017 rst asserted mid-stream SHALL discard all stored words; the first write after rst deasserts SHALL land at address 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios (default parameters unless stated):
- Fill and drain: rst, then 16 writes 0x00..0x0F, then 16 reads -> full=1 after the 16th write; data_out sequence 0x00..0x0F with 1-cycle latency; empty=1 at end; no error flags.
- Thresholds: write 2 words -> almost_empty=1; 3rd word -> almost_empty=0; 14th word -> almost_full=1.
- Full with simultaneous request: at count=16 assert wr_en=1, rd_en=1, data_in=0xAA -> count=15, overflow=1, 0xAA never read out.
- Wrap-around: 10 writes, 10 reads, then 12 more writes 0x20..0x2B and 12 reads -> data in order, count returns to 0, no error flags.
- Underflow, clr_err, flush: rd_en at empty -> underflow=1; clr_err pulse -> underflow=0; write 5 words, flush with wr_en=1 -> count=0, empty=1.
- fwft_p=1 and mid-stream reset: write 0x55 -> data_out=0x55 the cycle after, with no rd_en; rst at count=7 -> count=0, empty=1, data_out=0; next write then read returns the new word.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-decoded status flags, sticky overflow/underflow
// flags, flush, and either registered-read or first-word-fall-through output.
module sync_fifo #(
    parameter int data_width_p    = 8,
    parameter int mem_depth_p     = 16,
    parameter int addr_size_p     = 4,
    parameter int afull_thresh_p  = 14,
    parameter int aempty_thresh_p = 2,
    parameter int fwft_p          = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [data_width_p-1:0] data_in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic                    flush,
    input  logic                    clr_err,
    output logic [data_width_p-1:0] data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [addr_size_p:0]    count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam logic [addr_size_p:0]   depth_c   = (addr_size_p + 1)'(mem_depth_p);
    localparam logic [addr_size_p:0]   afull_c   = (addr_size_p + 1)'(afull_thresh_p);
    localparam logic [addr_size_p:0]   aempty_c  = (addr_size_p + 1)'(aempty_thresh_p);
    localparam logic [addr_size_p:0]   cnt_one_c = (addr_size_p + 1)'(1);
    localparam logic [addr_size_p-1:0] ptr_one_c = addr_size_p'(1);

    logic [data_width_p-1:0] mem_r [mem_depth_p];
    logic [addr_size_p-1:0]  wr_ptr_r;
    logic [addr_size_p-1:0]  rd_ptr_r;
    logic [addr_size_p:0]    count_r;
    logic [addr_size_p:0]    count_s;
    logic                    full_r;
    logic                    empty_r;
    logic                    afull_r;
    logic                    aempty_r;
    logic                    overflow_r;
    logic                    underflow_r;
    logic [data_width_p-1:0] dout_r;
    logic                    wr_acc_s;
    logic                    rd_acc_s;
    logic                    ovf_set_s;
    logic                    udf_set_s;

    // Accept decode and next occupancy; flush and rst suppress both accepts.
    always_comb begin
        wr_acc_s  = wr_en && !full_r  && !flush && !rst;
        rd_acc_s  = rd_en && !empty_r && !flush && !rst;
        ovf_set_s = wr_en && full_r;
        udf_set_s = rd_en && empty_r;
        count_s   = count_r;
        if (flush) begin
            count_s = {(addr_size_p + 1){1'b0}};
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_s = count_r + cnt_one_c;
                2'b01:   count_s = count_r - cnt_one_c;
                default: count_s = count_r;
            endcase
        end
    end

    // Pointers, occupancy and status flags, all decoded from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {addr_size_p{1'b0}};
            rd_ptr_r <= {addr_size_p{1'b0}};
            count_r  <= {(addr_size_p + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_r <= {addr_size_p{1'b0}};
                rd_ptr_r <= {addr_size_p{1'b0}};
            end else begin
                if (wr_acc_s) begin
                    wr_ptr_r <= wr_ptr_r + ptr_one_c;
                end
                if (rd_acc_s) begin
                    rd_ptr_r <= rd_ptr_r + ptr_one_c;
                end
            end
            count_r  <= count_s;
            full_r   <= (count_s == depth_c);
            empty_r  <= (count_s == {(addr_size_p + 1){1'b0}});
            afull_r  <= (count_s >= afull_c);
            aempty_r <= (count_s <= aempty_c);
        end
    end

    // Sticky error flags; a coincident set beats clr_err, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (udf_set_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Registered read word (only loaded in registered-read mode).
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= {data_width_p{1'b0}};
        end else if ((fwft_p == 0) && rd_acc_s) begin
            dout_r <= mem_r[rd_ptr_r];
        end
    end

    generate
        if (fwft_p != 0) begin : g_fwft
            // Head word falls through; while empty the reset/held register shows.
            assign data_out = empty_r ? dout_r : mem_r[rd_ptr_r];
        end else begin : g_reg
            assign data_out = dout_r;
        end
    endgenerate

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
